// File: rtl/serial_deser.sv
// Serial-to-parallel deserializer with a valid/ready output stage.
// Detects framing errors and overruns of unread words.
module serial_deser #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             str,
  input  logic             din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  input  logic             ovr_clr
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] shifted;
  logic             last;
  logic             word_vld;

  // Shift register with the current din folded in
  always_comb begin
    shifted = '0;
    if (MSB_FIRST) begin
      shifted = {shreg_q[WIDTH-2:0], din};
    end else begin
      shifted = {din, shreg_q[WIDTH-1:1]};
    end
  end

  assign last = (bitcnt_q == CW'(WIDTH - 1));

  // Frame FSM: next state, counter, shifter and error detection
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    ferr_d   = 1'b0;
    word_vld = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SHIFT;
          bitcnt_d = '0;
          shreg_d  = '0;
        end
      end
      SHIFT: begin
        if (start) begin
          ferr_d   = 1'b1;
          bitcnt_d = '0;
          shreg_d  = '0;
        end else begin
          shreg_d  = shifted;
          bitcnt_d = bitcnt_q + CW'(1);
          if (str && last) begin
            word_vld = 1'b1;
            state_d  = IDLE;
          end else if (str || last) begin
            ferr_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output handshake and sticky overrun
  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (word_vld && (!valid_q || ready)) begin
      dout_d  = shifted;
      valid_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
    if (word_vld && valid_q && !ready) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign dout      = dout_q;
  assign valid     = valid_q;
  assign busy      = (state_q == SHIFT);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_serial_deser.sv
// Bench for serial_deser: MSB- and LSB-first instances driven in
// parallel, checked against a queue-based frame model every cycle.
module tb_serial_deser;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, str, din, ready, ovr_clr;
  logic [W-1:0] dout_m, dout_l;
  logic         valid_m, valid_l, busy_m, busy_l;
  logic         ferr_m, ferr_l, ovr_m, ovr_l;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .start(start), .str(str), .din(din),
    .dout(dout_m), .valid(valid_m), .ready(ready), .busy(busy_m),
    .frame_err(ferr_m), .overrun(ovr_m), .ovr_clr(ovr_clr)
  );

  serial_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .start(start), .str(str), .din(din),
    .dout(dout_l), .valid(valid_l), .ready(ready), .busy(busy_l),
    .frame_err(ferr_l), .overrun(ovr_l), .ovr_clr(ovr_clr)
  );

  // Frame model: collect sampled bits in a queue, build words arithmetically
  bit           q_bits[$];
  bit           m_inf = 0;
  bit           m_valid = 0, m_ferr = 0, m_ovr = 0;
  logic [W-1:0] m_dm = '0, m_dl = '0;
  bit           got, oset;

  function automatic logic [W-1:0] pack(input bit msb);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W; i++) begin
      if (q_bits[i]) begin
        if (msb) v = v + (W'(1) << (W - 1 - i));
        else     v = v + (W'(1) << i);
      end
    end
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_inf = 0; q_bits.delete();
      m_valid = 0; m_ferr = 0; m_ovr = 0;
      m_dm = '0; m_dl = '0;
    end else begin
      got = 0; oset = 0; m_ferr = 0;
      if (start) begin
        if (m_inf) m_ferr = 1;
        m_inf = 1;
        q_bits.delete();
      end else if (m_inf) begin
        q_bits.push_back(din);
        if (str && q_bits.size() == W) got = 1;
        else if (str || q_bits.size() == W) m_ferr = 1;
        if (str || q_bits.size() == W) m_inf = 0;
      end
      if (got && (!m_valid || ready)) begin
        m_dm = pack(1); m_dl = pack(0); m_valid = 1;
      end else begin
        if (got) oset = 1;
        if (m_valid && ready) m_valid = 0;
      end
      if (oset) m_ovr = 1;
      else if (ovr_clr) m_ovr = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got_v,
                     input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, got_v, exp_v, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_dout", 32'(dout_m), 32'(m_dm));
      chk("l_dout", 32'(dout_l), 32'(m_dl));
      chk("m_valid", 32'(valid_m), 32'(m_valid));
      chk("l_valid", 32'(valid_l), 32'(m_valid));
      chk("m_busy", 32'(busy_m), 32'(m_inf));
      chk("l_busy", 32'(busy_l), 32'(m_inf));
      chk("m_ferr", 32'(ferr_m), 32'(m_ferr));
      chk("l_ferr", 32'(ferr_l), 32'(m_ferr));
      chk("m_ovr", 32'(ovr_m), 32'(m_ovr));
      chk("l_ovr", 32'(ovr_l), 32'(m_ovr));
    end
  end

  task automatic cyc(input logic s, input logic t, input logic d);
    start = s; str = t; din = d;
    @(posedge clk); #1;
  endtask

  // start cycle, then nb bits of w MSB-first, str on bit strb (0 = none)
  task automatic send(input logic [15:0] w, input int nb, input int strb,
                      input bit rdy_str);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < nb; i++) begin
      if (rdy_str && i == nb - 1) ready = 1'b1;
      cyc(1'b0, (i + 1) == strb, w[15-i]);
    end
    if (rdy_str) ready = 1'b0;
    start = 1'b0; str = 1'b0; din = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; str = 1'b0; din = 1'b0;
    ready = 1'b0; ovr_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_valid", 32'(valid_m), 32'd0);
    chk("rst_dout", 32'(dout_m), 32'd0);
    chk("rst_busy", 32'(busy_m), 32'd0);
    cyc(0, 0, 0);

    // Nominal frame, both bit orders
    send(16'hA5C3, 16, 16, 0);
    chk("t2_dout", 32'(dout_m), 32'h0000A5C3);
    chk("t2_valid", 32'(valid_m), 32'd1);
    chk("t3_dout", 32'(dout_l), 32'h0000C3A5);
    ready = 1'b1; cyc(0, 0, 0); ready = 1'b0;
    chk("consume", 32'(valid_m), 32'd0);

    // Early strobe on bit 10
    send(16'hFFFF, 10, 10, 0);
    chk("t4a_ferr", 32'(ferr_m), 32'd1);
    chk("t4a_busy", 32'(busy_m), 32'd0);
    chk("t4a_valid", 32'(valid_m), 32'd0);
    cyc(0, 0, 0);
    chk("t4a_pulse", 32'(ferr_m), 32'd0);

    // Missing strobe at bit 16
    send(16'hFFFF, 16, 0, 0);
    chk("t4b_ferr", 32'(ferr_m), 32'd1);
    chk("t4b_busy", 32'(busy_m), 32'd0);
    cyc(0, 0, 0);

    // Restart mid-frame, then a good frame
    send(16'h5555, 5, 0, 0);
    send(16'h0F0F, 16, 16, 0);
    chk("rs_dout", 32'(dout_m), 32'h00000F0F);
    ready = 1'b1; cyc(0, 0, 0); ready = 1'b0;

    // start and str together in SHIFT
    cyc(1, 0, 0);
    cyc(0, 0, 1); cyc(0, 0, 1);
    cyc(1, 1, 0);
    chk("ss_ferr", 32'(ferr_m), 32'd1);
    chk("ss_busy", 32'(busy_m), 32'd1);
    repeat (18) cyc(0, 0, 0);

    // Overrun with back-to-back frames
    send(16'h1234, 16, 16, 0);
    send(16'hBEEF, 16, 16, 0);
    chk("t5_dout", 32'(dout_m), 32'h00001234);
    chk("t5_ovr", 32'(ovr_m), 32'd1);
    ovr_clr = 1'b1; cyc(0, 0, 0); ovr_clr = 1'b0;
    chk("t5_clr", 32'(ovr_m), 32'd0);

    // Consume and reload on the same edge
    send(16'hBEEF, 16, 16, 1);
    chk("t6_dout", 32'(dout_m), 32'h0000BEEF);
    chk("t6_ldout", 32'(dout_l), 32'h0000F77D);
    chk("t6_valid", 32'(valid_m), 32'd1);
    chk("t6_ovr", 32'(ovr_m), 32'd0);

    // Overrun, then reset mid-frame
    send(16'h0001, 16, 16, 0);
    chk("pre_ovr", 32'(ovr_m), 32'd1);
    cyc(1, 0, 0);
    repeat (6) cyc(0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_busy", 32'(busy_m), 32'd0);
    chk("t1_valid", 32'(valid_m), 32'd0);
    chk("t1_dout", 32'(dout_m), 32'd0);
    chk("t1_ovr", 32'(ovr_m), 32'd0);
    @(posedge clk); #1;
    chk("t1_ferr", 32'(ferr_m), 32'd0);
    rst_n = 1'b1;
    repeat (3) cyc(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
